// File: rtl/bram_port_arbiter_pkg.sv
// Shared types for the BRAM port arbiter: FSM state, read-tag format and
// the default RAM read latency.
package bram_arb_pkg;

    // Default RAM read latency, mem_en cycle to valid mem_dout.
    localparam int RD_LAT_DEF = 2;

    // Tag id width sized for the largest supported requester count (8).
    localparam int ID_W = 3;

    // INIT zero-fills the RAM after reset; ARB serves requesters.
    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } state_t;

    // One read-return pipeline stage: valid plus issuing requester id.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// Combinational round-robin pick: scans req upward from ptr with wrap and
// returns a one-hot grant, the granted index and the pointer that follows it.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic            en_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic [PW-1:0]   next_ptr_o,
    output logic            found_o
);

    logic [PW-1:0] cand;

    // First requester at or above ptr (wrapping) wins; pointer moves past it.
    always_comb begin
        gnt_o      = '0;
        idx_o      = '0;
        next_ptr_o = ptr_i;
        found_o    = 1'b0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_i) + k) % NREQ);
            if (en_i && !found_o && req_i[cand]) begin
                found_o     = 1'b1;
                idx_o       = cand;
                next_ptr_o  = PW'((int'(cand) + 1) % NREQ);
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port among NREQ requesters with round-robin arbitration,
// zero-fills the RAM after every reset, and routes read data back to the
// issuing requester through a tag pipeline matched to the RAM read latency.
//
// Handshake: req[i] is a valid held until accepted; gnt[i] (combinational,
// same cycle) is the acceptance. A cycle with req[i] && gnt[i] transfers
// the command; a req still high in the next cycle is a fresh command.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DW     = 36,
    parameter int AW     = 12,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic             clkA,
    input  logic             rstB,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_din,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [DW-1:0]    rsp_data,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_din,
    input  logic [DW-1:0]    mem_dout,
    output logic             init_done,
    output state_t           dbg_state_o
);

    localparam int PW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_din_q, mem_din_d;
    logic [ID_W-1:0] id_q, id_d;
    tag_t            tag_q [RD_LAT];

    logic            init_issue;
    logic            arb_en;
    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   pick_next_ptr;
    logic            pick_found;

    // Zero-fill writes go straight from the counter so the first one lands
    // in the first cycle after reset; reset itself silences the port.
    assign init_issue = (state_q == INIT) && !rstB;
    assign arb_en     = (state_q == ARB)  && !rstB;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .en_i       (arb_en),
        .req_i      (req),
        .ptr_i      (ptr_q),
        .gnt_o      (pick_gnt),
        .idx_o      (pick_idx),
        .next_ptr_o (pick_next_ptr),
        .found_o    (pick_found)
    );

    // Next-state: INIT counts through every address, ARB captures the winner.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        id_d       = id_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (pick_found) begin
                    ptr_d      = pick_next_ptr;
                    mem_en_d   = 1'b1;
                    mem_we_d   = req_we[pick_idx];
                    mem_addr_d = req_addr[int'(pick_idx)*AW +: AW];
                    mem_din_d  = req_din[int'(pick_idx)*DW +: DW];
                    id_d       = ID_W'(pick_idx);
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State, pointer, init counter and registered RAM command.
    always_ff @(posedge clkA) begin
        if (rstB) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            ptr_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            id_q       <= id_d;
        end
    end

    // Read tags ride alongside the RAM pipeline; reset drops in-flight reads.
    always_ff @(posedge clkA) begin
        if (rstB) begin
            for (int k = 0; k < RD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: mem_en_q && !mem_we_q, id: id_q};
            for (int k = 1; k < RD_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Decode the exiting tag into the one-hot response strobe.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = tag_q[RD_LAT-1].valid && (tag_q[RD_LAT-1].id == ID_W'(i));
        end
    end

    assign gnt         = pick_gnt;
    assign mem_en      = init_issue ? 1'b1  : mem_en_q;
    assign mem_we      = init_issue ? 1'b1  : mem_we_q;
    assign mem_addr    = init_issue ? cnt_q : mem_addr_q;
    assign mem_din     = init_issue ? '0    : mem_din_q;
    assign rsp_data    = mem_dout;
    assign init_done   = (state_q == ARB);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with AW=4 and a behavioural 2-cycle
// read-before-write RAM on the port.
module tb_bram_port_arbiter;

    localparam int NREQ   = 4;
    localparam int DW     = 36;
    localparam int AW     = 4;
    localparam int RD_LAT = 2;
    localparam int NCYC   = 128;

    logic               clkA = 1'b0;
    logic               rstB;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_din;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_din;
    logic [DW-1:0]      mem_dout;
    logic               init_done;
    bram_arb_pkg::state_t dbg_state;

    bram_port_arbiter #(
        .NREQ(NREQ), .DW(DW), .AW(AW), .RD_LAT(RD_LAT)
    ) dut (
        .clkA        (clkA),
        .rstB        (rstB),
        .req         (req),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_din     (req_din),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .init_done   (init_done),
        .dbg_state_o (dbg_state)
    );

    always #5 clkA = ~clkA;

    // RAM: read sampled before same-edge write, two registered read stages.
    logic [DW-1:0] ram [2**AW];
    logic [DW-1:0] rd_p1;
    always @(posedge clkA) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            else        rd_p1 <= ram[mem_addr];
        end
        mem_dout <= rd_p1;
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    logic [NREQ-1:0] exp_rv [NCYC];
    logic [DW-1:0]   exp_rd [NCYC];

    function automatic logic [DW-1:0] pat(input int a);
        return 36'h9_0000_0000 + DW'(a) * 36'h111;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clkA);
        cyc++;
        #1;
    endtask

    task automatic idle();
        req    = '0;
        req_we = '0;
    endtask

    task automatic set_cmd(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]              = 1'b1;
        req_we[i]           = we;
        req_addr[i*AW +: AW] = a;
        req_din[i*DW +: DW]  = d;
    endtask

    // Called in the cycle a read is granted: response due 3 cycles later.
    task automatic expect_rsp(input int id, input logic [DW-1:0] d);
        exp_rv[cyc+1+RD_LAT] = NREQ'(1) << id;
        exp_rd[cyc+1+RD_LAT] = d;
    endtask

    task automatic check_cycle();
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv[cyc]));
        if (exp_rv[cyc] != '0) chk("rsp_data", 64'(rsp_data), 64'(exp_rd[cyc]));
    endtask

    // Starts in the first INIT cycle; leaves the bench in the last fill cycle.
    task automatic init_sweep();
        for (int i = 0; i < 2**AW; i++) begin
            if (i > 0) next_cycle();
            check_cycle();
            chk("init_en",   64'(mem_en), 64'(1));
            chk("init_we",   64'(mem_we), 64'(1));
            chk("init_addr", 64'(mem_addr), 64'(i));
            chk("init_din",  64'(mem_din), 64'(0));
            chk("init_gnt",  64'(gnt), 64'(0));
            chk("init_done_low", 64'(init_done), 64'(0));
        end
    endtask

    initial begin
        for (int c = 0; c < NCYC; c++) begin
            exp_rv[c] = '0;
            exp_rd[c] = '0;
        end
        rstB     = 1'b1;
        req_addr = '0;
        req_din  = '0;
        idle();
        set_cmd(0, 1'b0, 4'd0, '0);   // held from reset through INIT

        // Reset state.
        repeat (3) @(posedge clkA);
        #1;
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_din", 64'(mem_din), 64'(0));
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_init_done", 64'(init_done), 64'(0));

        // Zero fill: cycles 0..15.
        rstB = 1'b0;
        init_sweep();

        // Cycle 16: first ARB cycle, held req[0] granted right away.
        next_cycle();
        check_cycle();
        chk("init_done_rise", 64'(init_done), 64'(1));
        chk("first_gnt", 64'(gnt), 64'(4'b0001));
        chk("first_arb_mem_en", 64'(mem_en), 64'(0));
        expect_rsp(0, '0);

        // Cycle 17: requester 2 writes 0xABC to address 5.
        next_cycle();
        idle();
        set_cmd(2, 1'b1, 4'd5, 36'hABC);
        check_cycle();
        chk("wr_gnt", 64'(gnt), 64'(4'b0100));
        chk("rd0_mem_en", 64'(mem_en), 64'(1));
        chk("rd0_mem_we", 64'(mem_we), 64'(0));
        chk("rd0_mem_addr", 64'(mem_addr), 64'(0));

        // Cycle 18: requester 2 reads address 5 back.
        next_cycle();
        set_cmd(2, 1'b0, 4'd5, '0);
        check_cycle();
        chk("rd_gnt", 64'(gnt), 64'(4'b0100));
        chk("wr_mem_we", 64'(mem_we), 64'(1));
        chk("wr_mem_addr", 64'(mem_addr), 64'(5));
        chk("wr_mem_din", 64'(mem_din), 64'(36'hABC));
        expect_rsp(2, 36'hABC);

        // Cycles 19..20: idle, then a bubble on the port.
        next_cycle();
        idle();
        check_cycle();
        chk("idle_gnt", 64'(gnt), 64'(0));
        next_cycle();
        check_cycle();
        chk("bubble_mem_en", 64'(mem_en), 64'(0));

        // Cycles 21..24: requester 3 preloads addresses 8..11 (ptr ends at 0).
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            idle();
            set_cmd(3, 1'b1, AW'(8 + k), pat(8 + k));
            check_cycle();
            chk("pre_gnt", 64'(gnt), 64'(4'b1000));
        end

        // Cycles 25..32: all four read continuously; order 0,1,2,3,0,...
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            idle();
            for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, AW'(8 + i), '0);
            check_cycle();
            chk("all_gnt", 64'(gnt), 64'(NREQ'(1) << (k % 4)));
            chk("all_mem_en", 64'(mem_en), 64'(1));
            chk("all_mem_addr", 64'(mem_addr), 64'(8 + ((k + 3) % 4)));
            expect_rsp(k % 4, pat(8 + (k % 4)));
        end

        // Cycle 33: requester 1 writes address 12 (ptr becomes 2).
        next_cycle();
        idle();
        set_cmd(1, 1'b1, 4'd12, pat(12));
        check_cycle();
        chk("w12_gnt", 64'(gnt), 64'(4'b0010));

        // Cycles 34..37: only 1 and 3 request from ptr=2: order 3,1,3,1.
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            idle();
            set_cmd(1, 1'b0, 4'd12, '0);
            set_cmd(3, 1'b0, 4'd10, '0);
            check_cycle();
            if (k % 2 == 0) begin
                chk("pair_gnt", 64'(gnt), 64'(4'b1000));
                expect_rsp(3, pat(10));
            end else begin
                chk("pair_gnt", 64'(gnt), 64'(4'b0010));
                expect_rsp(1, pat(12));
            end
        end

        // Cycles 38..40: drain.
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            idle();
            check_cycle();
        end

        // Cycles 41..42: two reads go in flight (ptr 2 -> grant 0, then 1).
        next_cycle();
        set_cmd(0, 1'b0, 4'd8, '0);
        check_cycle();
        chk("fl0_gnt", 64'(gnt), 64'(4'b0001));
        next_cycle();
        idle();
        set_cmd(1, 1'b0, 4'd9, '0);
        check_cycle();
        chk("fl1_gnt", 64'(gnt), 64'(4'b0010));

        // Cycle 43: one-cycle reset pulse.
        next_cycle();
        idle();
        rstB = 1'b1;
        check_cycle();
        chk("rstpulse_gnt", 64'(gnt), 64'(0));

        // Cycles 44..59: refill, in-flight reads discarded.
        next_cycle();
        rstB = 1'b0;
        init_sweep();

        // Cycle 60: back in ARB.
        next_cycle();
        check_cycle();
        chk("refill_done", 64'(init_done), 64'(1));
        chk("refill_state", 64'(dbg_state), 64'(bram_arb_pkg::ARB));
        chk("refill_gnt", 64'(gnt), 64'(0));

        // Cycles 61..62: after the refill, ptr is back at 0.
        next_cycle();
        for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b1, 4'd0, '0);
        check_cycle();
        chk("ptr_reset_gnt", 64'(gnt), 64'(4'b0001));
        next_cycle();
        idle();
        check_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter and initialiser for one port of the team's block-RAM macros, which have a 2-cycle registered read pipeline. The block shares a single BRAM port among NREQ requesters. It returns read data to the issuing requester with a tagged valid, and zero-fills the whole memory after every reset before accepting traffic. It sits between the MobileNet buffer clients and one RAM port.

## Interface
- NREQ, 4: number of requesters (2..8)
- DW, 36: data width
- AW, 12: address width
- RD_LAT, 2: RAM read latency, from mem_en cycle to valid mem_dout

- clkA  in  1  clock; all logic on posedge
- rstB  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester access request; held until granted
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_din  in  NREQ*DW  packed write data
- gnt  out  NREQ  one-hot, combinational; request accepted this cycle
- rsp_valid  out  NREQ  one-hot read-return strobe
- rsp_data  out  DW  read data, equal to mem_dout
- mem_en, mem_we  out  1  RAM port enable / write enable
- mem_addr  out  AW  RAM address
- mem_din  out  DW  RAM write data
- mem_dout  in  DW  RAM read data
- init_done  out  1  high once zero-fill is complete

## Operation
- FSM states INIT and ARB. Reset enters INIT with init counter = 0.
- INIT: each cycle issues mem_en=1, mem_we=1, mem_addr=counter, mem_din=0, then increments the counter. After address 2^AW-1 is written, go to ARB. gnt stays 0 throughout INIT.
- ARB: a round-robin pointer `ptr` (reset 0) selects the granted requester. Scan from `ptr` upward with wrap and grant the first i with req[i]=1. The grant is combinational in the same cycle. On a grant, `ptr` becomes (i+1) mod NREQ; with no grant, `ptr` holds.
- The granted command (we/addr/din) is registered onto mem_* in the next cycle with mem_en=1. mem_en is 0 in any cycle that follows a no-grant cycle. mem_din is don't-care for reads but is driven with the captured value.
- A granted requester drops req or presents a new command in the next cycle. A req held high is treated as a new request.
- Read tag pipeline: RD_LAT stages of {valid, id}. The stage is loaded when mem_en=1 and mem_we=0. rsp_valid[id] asserts in the cycle the tag exits the pipeline. rsp_data = mem_dout (wire).
- Writes produce no response.
- Responses return strictly in issue order; at most one per cycle.
- Full throughput: one access per cycle with no bubbles.

## Timing
- Reset values: gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, rsp_valid=0, init_done=0, ptr=0, tag pipeline cleared.
- INIT takes 2^AW cycles of mem_en. init_done rises in the first ARB cycle, the cycle after the last zero write. The first gnt is possible in that same cycle.
- Read latency: gnt in cycle t, mem_en in t+1, rsp_valid in t+1+RD_LAT (t+3 by default).
- Write visible to a read granted in cycle t+1 or later, per the RAM's read-before-write behaviour on the same port.
- rstB mid-operation: in-flight reads are discarded with no rsp_valid, the FSM re-enters INIT at address 0, and ptr returns to 0.
- Simultaneous requests: only one grant per cycle. Every continuously requesting client is granted within NREQ cycles.
- req asserted during INIT is ignored, not latched.

## Structure
- Package bram_arb_pkg: state enum {INIT, ARB}; default RD_LAT constant; tag struct {valid, id[$clog2(NREQ)-1:0]}.
- One sub-module, rr_pick: combinational round-robin select (req, ptr -> one-hot gnt, next_ptr). The FSM, init counter, command register and tag pipeline stay in the top module.

## Test plan
- AW=4, reset released: 16 consecutive cycles of mem_en=1, mem_we=1, addr 0..15, din 0. init_done=1 on cycle 17, with no gnt before it.
- Requester 2 writes 0xABC to address 5, then reads address 5: gnt[2] on the read in cycle t, rsp_valid[2]=1 with rsp_data=0xABC in cycle t+3; no other rsp_valid bits.
- All four requesters hold req=1, all reads: gnt sequence 0,1,2,3,0,1… with mem_en=1 every cycle and rsp_valid following the same order 3 cycles later.
- Only requesters 1 and 3 request, ptr=2: gnt order 3,1,3,1. Each response is routed to the correct id with data matching a preloaded pattern.
- Two reads in flight, rstB pulsed for 1 cycle: no rsp_valid afterwards, mem_addr restarts at 0 with mem_we=1, and init_done=0 until the fill completes.
- req[0]=1 held from reset: gnt[0] first asserts in the cycle init_done rises; that request is not granted during INIT.
